// File: rtl/decode_stage.sv
// decode_stage: buffered RV32I decode stage between fetch and execute.
//
// Fetched words enter a circular instruction buffer over a valid/ready
// handshake. The buffer head is decoded combinationally and captured in an
// output register that stalls while execute holds off (id_valid && !ex_ready).
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   if_valid/if_ready    fetch handshake; if_inst, if_pc carried with it
//   flush                drop all buffered work and the output register
//   ex_ready             execute takes id_* this cycle
//   id_valid, id_pc, id_inst   decoded instruction and its origin
//   rs1/rs2/rd, alu_ctrl, branch, ls_type, sext_type, wb_ctrl,
//   jump, jump_type, alu_src1, alu_src2, we_reg, we_mem   control fields
//   md_en, md_op         multiply/divide decode
//   illegal              decoded word is not a legal instruction
//   ibuf_count           occupied buffer entries
//
// Build option: define M_EXT_EN to decode RV32M (funct7 0000001 on OP).
// Without it those words are reported illegal and md_en/md_op stay 0.
module decode_stage #(
    parameter int IBUF_DEPTH = 4,
    parameter int PC_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_valid,
    output logic                          if_ready,
    input  logic [31:0]                   if_inst,
    input  logic [PC_W-1:0]               if_pc,
    input  logic                          flush,
    input  logic                          ex_ready,
    output logic                          id_valid,
    output logic [PC_W-1:0]               id_pc,
    output logic [31:0]                   id_inst,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [4:0]                    rd,
    output logic [3:0]                    alu_ctrl,
    output logic [2:0]                    branch,
    output logic [3:0]                    ls_type,
    output logic [2:0]                    sext_type,
    output logic [1:0]                    wb_ctrl,
    output logic                          jump,
    output logic                          jump_type,
    output logic                          alu_src1,
    output logic                          alu_src2,
    output logic                          we_reg,
    output logic                          we_mem,
    output logic                          md_en,
    output logic [2:0]                    md_op,
    output logic                          illegal,
    output logic [$clog2(IBUF_DEPTH):0]   ibuf_count
);
    localparam int AW = $clog2(IBUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                           ALU_SLT = 4'b0110, ALU_SLTU = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA = 4'b1001, ALU_NOP = 4'b1110;
    localparam logic [2:0] BR_NT = 3'b010;
    localparam logic [3:0] LS_NONE = 4'b1111;
    localparam logic [2:0] SX_I = 3'b000, SX_B = 3'b001, SX_J = 3'b010,
                           SX_U = 3'b011, SX_S = 3'b110;
    localparam logic [1:0] WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b11;

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic [3:0] alu_ctrl;
        logic [2:0] branch;
        logic [3:0] ls_type;
        logic [2:0] sext_type;
        logic [1:0] wb_ctrl;
        logic       jump, jump_type, alu_src1, alu_src2, we_reg, we_mem, md_en;
        logic [2:0] md_op;
        logic       illegal;
    } dec_t;

    // Bubble / killed-instruction encoding; also the reset value.
    function automatic dec_t dec_nop();
        dec_t d;
        d          = '0;
        d.alu_ctrl = ALU_NOP;
        d.branch   = BR_NT;
        d.ls_type  = LS_NONE;
        return d;
    endfunction

    // alt selects SUB/SRA; only meaningful for funct3 000 and 101.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ---------------- instruction buffer ----------------
    logic [31:0]     mem_inst [IBUF_DEPTH];
    logic [PC_W-1:0] mem_pc   [IBUF_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;

    assign if_ready = ibuf_count < CW'(IBUF_DEPTH);
    assign push     = if_valid && if_ready && !flush;
    assign pop      = (ibuf_count != '0) && (!id_valid || ex_ready) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= if_inst;
            mem_pc[wr_ptr]   <= if_pc;
        end
    end

    // ---------------- decode of buffer head ----------------
    logic [31:0] hd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        ill;
    dec_t        d, dec;

    assign hd  = mem_inst[rd_ptr];
    assign opc = hd[6:0];
    assign f3  = hd[14:12];
    assign f7  = hd[31:25];

    always_comb begin
        d   = dec_nop();
        ill = 1'b0;
        case (opc)
            7'b0110011: begin // OP
                d.rs1 = hd[19:15];
                d.rs2 = hd[24:20];
                d.rd  = hd[11:7];
                if (f7 == 7'b0000001) begin
`ifdef M_EXT_EN
                    d.md_en  = 1'b1;
                    d.md_op  = f3;
                    d.we_reg = 1'b1;
`else
                    ill = 1'b1;
`endif
                end else if (f7 == 7'b0000000 ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    d.alu_ctrl = alu_of(f3, f7[5]);
                    d.we_reg   = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            7'b0010011: begin // OP-IMM; bit 30 is immediate except on shifts
                d.rs1      = hd[19:15];
                d.rd       = hd[11:7];
                d.alu_src2 = 1'b1;
                d.we_reg   = 1'b1;
                d.alu_ctrl = alu_of(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
            end
            7'b0000011: begin // LOAD
                d.rs1      = hd[19:15];
                d.rd       = hd[11:7];
                d.alu_ctrl = ALU_ADD;
                d.alu_src2 = 1'b1;
                d.ls_type  = {f3, 1'b0};
                d.wb_ctrl  = WB_LOAD;
                d.we_reg   = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
            end
            7'b0100011: begin // STORE
                d.rs1       = hd[19:15];
                d.rs2       = hd[24:20];
                d.alu_ctrl  = ALU_ADD;
                d.alu_src2  = 1'b1;
                d.sext_type = SX_S;
                d.ls_type   = {f3, 1'b1};
                d.we_mem    = 1'b1;
                if (f3 > 3'b010) ill = 1'b1;
            end
            7'b1100011: begin // BRANCH: compare via subtract
                d.rs1       = hd[19:15];
                d.rs2       = hd[24:20];
                d.alu_ctrl  = ALU_SUB;
                d.branch    = f3;
                d.sext_type = SX_B;
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            7'b1101111: begin // JAL: ALU forms PC + imm, rd gets PC+4
                d.rd        = hd[11:7];
                d.alu_ctrl  = ALU_ADD;
                d.alu_src1  = 1'b1;
                d.alu_src2  = 1'b1;
                d.sext_type = SX_J;
                d.wb_ctrl   = WB_PC4;
                d.jump      = 1'b1;
                d.jump_type = 1'b1;
                d.we_reg    = 1'b1;
            end
            7'b1100111: begin // JALR
                d.rs1       = hd[19:15];
                d.rd        = hd[11:7];
                d.alu_ctrl  = ALU_ADD;
                d.alu_src2  = 1'b1;
                d.sext_type = SX_I;
                d.wb_ctrl   = WB_PC4;
                d.jump      = 1'b1;
                d.we_reg    = 1'b1;
                if (f3 != 3'b000) ill = 1'b1;
            end
            7'b0110111, 7'b0010111: begin // LUI (0 + imm) / AUIPC (PC + imm)
                d.rd        = hd[11:7];
                d.alu_ctrl  = ALU_ADD;
                d.alu_src1  = opc[5] ? 1'b0 : 1'b1;
                d.alu_src2  = 1'b1;
                d.sext_type = SX_U;
                d.we_reg    = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        dec = d;
        if (hd == 32'd0) begin
            dec = dec_nop();
        end else if (ill) begin
            dec         = dec_nop();
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0) dec.we_reg = 1'b0;
    end

    // ---------------- pointers, count, output register ----------------
    dec_t q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ibuf_count <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_inst    <= '0;
            q          <= dec_nop();
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ibuf_count <= '0;
            id_valid   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   ibuf_count <= ibuf_count + CW'(1);
                2'b01:   ibuf_count <= ibuf_count - CW'(1);
                default: ibuf_count <= ibuf_count;
            endcase
            if (pop) begin
                id_valid <= 1'b1;
                id_pc    <= mem_pc[rd_ptr];
                id_inst  <= hd;
                q        <= dec;
            end else if (ex_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

    assign rs1       = q.rs1;
    assign rs2       = q.rs2;
    assign rd        = q.rd;
    assign alu_ctrl  = q.alu_ctrl;
    assign branch    = q.branch;
    assign ls_type   = q.ls_type;
    assign sext_type = q.sext_type;
    assign wb_ctrl   = q.wb_ctrl;
    assign jump      = q.jump;
    assign jump_type = q.jump_type;
    assign alu_src1  = q.alu_src1;
    assign alu_src2  = q.alu_src2;
    assign we_reg    = q.we_reg;
    assign we_mem    = q.we_mem;
    assign md_en     = q.md_en;
    assign md_op     = q.md_op;
    assign illegal   = q.illegal;
endmodule
